// File: rtl/mmio_store_unit_pkg.sv
// Shared constants for the MEM-stage store path and the load-result mux:
// region decode bits, IO offsets, store funct3 codes and lane helpers.
package mmio_store_unit_pkg;

   localparam int DMEM_BIT = 28;
   localparam int IMEM_BIT = 29;

   localparam logic [1:0] REGION_MEM  = 2'b00;
   localparam logic [1:0] REGION_BIOS = 2'b01;
   localparam logic [1:0] REGION_IO   = 2'b10;

   localparam logic [7:0] IO_UART_CTRL = 8'h00;
   localparam logic [7:0] IO_UART_RX   = 8'h04;
   localparam logic [7:0] IO_UART_TX   = 8'h08;
   localparam logic [7:0] IO_CYC       = 8'h10;
   localparam logic [7:0] IO_INSTR     = 8'h14;
   localparam logic [7:0] IO_CTR_RST   = 8'h18;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  funct3;
   } store_req_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
   endfunction

   function automatic logic store_aligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_SH:   return ~a[0];
         F3_SW:   return a == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_SB:   return 4'b0001 << a;
         F3_SH:   return a[1] ? 4'b1100 : 4'b0011;
         F3_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         F3_SB:   return {4{d[7:0]}};
         F3_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mmio_store_unit_io_counters.sv
// Free-running cycle counter and retired-instruction counter, both
// clearable by a memory-mapped store; clear wins over increment.
module io_counters
   import mmio_store_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        retire_i,
   output logic [31:0] cyc_ctr_o,
   output logic [31:0] instr_ctr_o
);

   logic [31:0] cyc_q, cyc_d;
   logic [31:0] instr_q, instr_d;

   always_comb begin
      cyc_d   = cyc_q + 32'd1;
      instr_d = instr_q + {31'd0, retire_i};
      if (clr_i) begin
         cyc_d   = '0;
         instr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q   <= '0;
         instr_q <= '0;
      end else begin
         cyc_q   <= cyc_d;
         instr_q <= instr_d;
      end
   end

   assign cyc_ctr_o   = cyc_q;
   assign instr_ctr_o = instr_q;

endmodule

// File: rtl/mmio_store_unit.sv
// MEM-stage store unit: byte-lane enables and replicated write data for
// DMEM/IMEM, plus the UART TX holding register and counter-clear IO writes.
module mmio_store_unit
   import mmio_store_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             store_en,
   input  logic             stall,
   input  logic             instr_retire,
   input  logic [WIDTH-1:0] store_addr,
   input  logic [WIDTH-1:0] store_data,
   input  logic [2:0]       store_funct3,
   input  logic             imem_wr_allow,
   output logic [3:0]       dmem_we,
   output logic [3:0]       imem_we,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             misaligned,
   output logic [7:0]       uart_tx_data_in,
   output logic             uart_tx_data_in_valid,
   input  logic             uart_tx_data_in_ready,
   output logic             uart_tx_status_ready,
   output logic [WIDTH-1:0] cyc_ctr,
   output logic [WIDTH-1:0] instr_ctr
);

   store_req_t req;
   logic       req_go, aligned, active;
   logic [3:0] mask;
   logic       in_mem, in_io, tx_wr, ctr_clr;
   logic       tx_valid_q, tx_valid_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       unused_addr;

   assign req = '{addr: store_addr, data: store_data, funct3: store_funct3};

   assign req_go     = store_en & ~stall & f3_legal(req.funct3);
   assign aligned    = store_aligned(req.funct3, req.addr[1:0]);
   assign active     = req_go & aligned;
   assign misaligned = req_go & ~aligned;

   assign mask      = lane_mask(req.funct3, req.addr[1:0]);
   assign mem_wdata = lane_wdata(req.funct3, req.data);

   // Both region bits may be set at once; each memory decodes independently.
   assign in_mem  = active & (req.addr[31:30] == REGION_MEM);
   assign dmem_we = (in_mem & req.addr[DMEM_BIT]) ? mask : 4'b0000;
   assign imem_we = (in_mem & req.addr[IMEM_BIT] & imem_wr_allow) ? mask : 4'b0000;

   assign in_io   = active & (req.addr[31:30] == REGION_IO);
   assign tx_wr   = in_io & (req.addr[7:0] == IO_UART_TX);
   assign ctr_clr = in_io & (req.addr[7:0] == IO_CTR_RST);

   assign unused_addr = ^req.addr[27:8];

   // A store that lands while a byte is still pending is dropped, even if
   // the handshake completes on the same edge.
   always_comb begin
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      if (tx_valid_q) begin
         if (uart_tx_data_in_ready) tx_valid_d = 1'b0;
      end else if (tx_wr) begin
         tx_valid_d = 1'b1;
         tx_data_d  = req.data[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign uart_tx_data_in       = tx_data_q;
   assign uart_tx_data_in_valid = tx_valid_q;
   assign uart_tx_status_ready  = ~tx_valid_q;

   io_counters u_ctr (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (ctr_clr),
      .retire_i    (instr_retire & ~stall),
      .cyc_ctr_o   (cyc_ctr),
      .instr_ctr_o (instr_ctr)
   );

endmodule

// File: tb/tb_mmio_store_unit.sv
// Self-checking bench for mmio_store_unit: directed table, hand-written
// UART/counter sequences, and randomized traffic against a lane-level model.
module tb_mmio_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        store_en, stall, instr_retire, imem_wr_allow, ready;
   logic [31:0] addr, data;
   logic [2:0]  f3;
   logic [3:0]  dmem_we, imem_we;
   logic [31:0] mem_wdata, cyc_ctr, instr_ctr;
   logic        misaligned, tx_valid, status_ready;
   logic [7:0]  tx_byte;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_cyc, m_instr;
   logic        m_valid;
   logic [7:0]  m_byte;

   always #5 clk = ~clk;

   mmio_store_unit #(.WIDTH(32)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .store_en              (store_en),
      .stall                 (stall),
      .instr_retire          (instr_retire),
      .store_addr            (addr),
      .store_data            (data),
      .store_funct3          (f3),
      .imem_wr_allow         (imem_wr_allow),
      .dmem_we               (dmem_we),
      .imem_we               (imem_we),
      .mem_wdata             (mem_wdata),
      .misaligned            (misaligned),
      .uart_tx_data_in       (tx_byte),
      .uart_tx_data_in_valid (tx_valid),
      .uart_tx_data_in_ready (ready),
      .uart_tx_status_ready  (status_ready),
      .cyc_ctr               (cyc_ctr),
      .instr_ctr             (instr_ctr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Lane-level reference: a store of size sz at byte offset off touches
   // bytes [off, off+sz); byte b of wdata is data byte (b mod sz).
   function automatic void model_comb(output logic [3:0] dwe, output logic [3:0] iwe,
                                      output logic [31:0] wd, output logic mis,
                                      output logic act);
      int sz, off;
      logic [3:0] lanes;
      sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      off = int'(addr[1:0]);
      lanes = '0;
      wd = data;
      mis = 1'b0;
      act = 1'b0;
      if (sz != 0) begin
         for (int b = 0; b < 4; b++) begin
            wd[8*b +: 8] = data[8*(b % sz) +: 8];
            if (b >= off && b < off + sz) lanes[b] = 1'b1;
         end
         if (store_en && !stall) begin
            mis = (off % sz) != 0;
            act = !mis;
         end
      end
      dwe = (act && addr[31:30] == 2'b00 && addr[28]) ? lanes : 4'b0000;
      iwe = (act && addr[31:30] == 2'b00 && addr[29] && imem_wr_allow) ? lanes : 4'b0000;
   endfunction

   task automatic chk_comb_model(input string tag);
      logic [3:0] d, i;
      logic [31:0] w;
      logic mis, act;
      model_comb(d, i, w, mis, act);
      chk({tag, ".dmem_we"}, {28'd0, dmem_we}, {28'd0, d});
      chk({tag, ".imem_we"}, {28'd0, imem_we}, {28'd0, i});
      chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, mis});
      if (f3 inside {3'd0, 3'd1, 3'd2}) chk({tag, ".wdata"}, mem_wdata, w);
   endtask

   // One clock edge: advance the model from the current inputs, then compare.
   task automatic tick(input string tag);
      logic [3:0] d, i;
      logic [31:0] w, nc, ni;
      logic mis, act, io, tx, clr, nv;
      logic [7:0] nb;
      model_comb(d, i, w, mis, act);
      io  = act && addr[31:30] == 2'b10;
      tx  = io && addr[7:0] == 8'h08;
      clr = io && addr[7:0] == 8'h18;
      nc = clr ? 32'd0 : m_cyc + 32'd1;
      ni = clr ? 32'd0 : m_instr + ((instr_retire && !stall) ? 32'd1 : 32'd0);
      nv = m_valid;
      nb = m_byte;
      if (m_valid) begin
         if (ready) nv = 1'b0;
      end else if (tx) begin
         nv = 1'b1;
         nb = data[7:0];
      end
      @(posedge clk);
      m_cyc = nc; m_instr = ni; m_valid = nv; m_byte = nb;
      #1;
      chk({tag, ".cyc"}, cyc_ctr, m_cyc);
      chk({tag, ".instr"}, instr_ctr, m_instr);
      chk({tag, ".valid"}, {31'd0, tx_valid}, {31'd0, m_valid});
      chk({tag, ".status"}, {31'd0, status_ready}, {31'd0, ~m_valid});
      chk({tag, ".byte"}, {24'd0, tx_byte}, {24'd0, m_byte});
   endtask

   task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] dt,
                        input logic en);
      f3 = f; addr = a; data = dt; store_en = en;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
      logic        en, stl, allow;
      logic [3:0]  dwe, iwe;
      logic [31:0] wd;
      logic        mis, chk_wd;
   } vec_t;

   vec_t tbl[11];

   initial begin
      rst_n = 1'b0;
      store_en = 0; stall = 0; instr_retire = 0; imem_wr_allow = 0; ready = 0;
      addr = '0; data = '0; f3 = '0;
      m_cyc = '0; m_instr = '0; m_valid = 1'b0; m_byte = '0;

      tbl[0]  = '{3'd0, 32'h1000_0003, 32'h0000_00A5, 1, 0, 0, 4'b1000, 4'b0000, 32'hA5A5_A5A5, 0, 1};
      tbl[1]  = '{3'd2, 32'h3000_0004, 32'h1234_5678, 1, 0, 0, 4'b1111, 4'b0000, 32'h1234_5678, 0, 1};
      tbl[2]  = '{3'd2, 32'h3000_0004, 32'h1234_5678, 1, 0, 1, 4'b1111, 4'b1111, 32'h1234_5678, 0, 1};
      tbl[3]  = '{3'd1, 32'h1000_0001, 32'h0000_BEEF, 1, 0, 0, 4'b0000, 4'b0000, 32'hBEEF_BEEF, 1, 1};
      tbl[4]  = '{3'd1, 32'h1000_0001, 32'h0000_BEEF, 1, 1, 0, 4'b0000, 4'b0000, 32'hBEEF_BEEF, 0, 1};
      tbl[5]  = '{3'd1, 32'h2000_0002, 32'h1234_CAFE, 1, 0, 1, 4'b0000, 4'b1100, 32'hCAFE_CAFE, 0, 1};
      tbl[6]  = '{3'd0, 32'h1000_0001, 32'hFFFF_FF77, 1, 0, 0, 4'b0010, 4'b0000, 32'h7777_7777, 0, 1};
      tbl[7]  = '{3'd2, 32'h5000_0000, 32'hDEAD_BEEF, 1, 0, 1, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 0, 1};
      tbl[8]  = '{3'd3, 32'h1000_0000, 32'h0102_0304, 1, 0, 0, 4'b0000, 4'b0000, 32'h0, 0, 0};
      tbl[9]  = '{3'd2, 32'h1000_0002, 32'h0102_0304, 1, 0, 0, 4'b0000, 4'b0000, 32'h0102_0304, 1, 1};
      tbl[10] = '{3'd2, 32'h3000_0000, 32'h0102_0304, 0, 0, 1, 4'b0000, 4'b0000, 32'h0102_0304, 0, 1};

      #3;
      chk("rst.byte", {24'd0, tx_byte}, 32'd0);
      chk("rst.valid", {31'd0, tx_valid}, 32'd0);
      chk("rst.status", {31'd0, status_ready}, 32'd1);
      chk("rst.cyc", cyc_ctr, 32'd0);
      chk("rst.instr", instr_ctr, 32'd0);
      #5 rst_n = 1'b1;

      for (int k = 0; k < 11; k++) begin
         drive(tbl[k].f3, tbl[k].addr, tbl[k].data, tbl[k].en);
         stall = tbl[k].stl; imem_wr_allow = tbl[k].allow;
         #1;
         chk($sformatf("tbl%0d.dmem_we", k), {28'd0, dmem_we}, {28'd0, tbl[k].dwe});
         chk($sformatf("tbl%0d.imem_we", k), {28'd0, imem_we}, {28'd0, tbl[k].iwe});
         chk($sformatf("tbl%0d.misaligned", k), {31'd0, misaligned}, {31'd0, tbl[k].mis});
         if (tbl[k].chk_wd) chk($sformatf("tbl%0d.wdata", k), mem_wdata, tbl[k].wd);
         tick($sformatf("tbl%0d", k));
      end
      stall = 0; imem_wr_allow = 0;

      // UART: byte held while ready=0, second store dropped, then drained.
      drive(3'd2, 32'h8000_0008, 32'h0000_0041, 1); ready = 0;
      tick("tx.load");
      chk("tx.load.valid", {31'd0, tx_valid}, 32'd1);
      chk("tx.load.byte", {24'd0, tx_byte}, 32'h41);
      store_en = 0;
      tick("tx.hold1");
      tick("tx.hold2");
      drive(3'd2, 32'h8000_0008, 32'h0000_0042, 1);
      tick("tx.drop");
      chk("tx.drop.byte", {24'd0, tx_byte}, 32'h41);
      chk("tx.drop.valid", {31'd0, tx_valid}, 32'd1);
      store_en = 0; ready = 1;
      tick("tx.drain");
      chk("tx.drain.valid", {31'd0, tx_valid}, 32'd0);
      chk("tx.drain.status", {31'd0, status_ready}, 32'd1);

      // Store coinciding with handshake completion is dropped.
      drive(3'd0, 32'h8000_0008, 32'h0000_0055, 1); ready = 0;
      tick("tx.sim.load");
      drive(3'd0, 32'h8000_0008, 32'h0000_0066, 1); ready = 1;
      tick("tx.sim.both");
      store_en = 0; ready = 0;
      tick("tx.sim.after");
      chk("tx.sim.valid", {31'd0, tx_valid}, 32'd0);
      chk("tx.sim.byte", {24'd0, tx_byte}, 32'h55);

      // Counters: clear (beats a simultaneous retire), 10 cycles, clear again.
      drive(3'd2, 32'h8000_0018, 32'h0, 1); instr_retire = 1;
      tick("ctr.clr0");
      chk("ctr.clr0.cyc", cyc_ctr, 32'd0);
      chk("ctr.clr0.instr", instr_ctr, 32'd0);
      store_en = 0;
      for (int i = 0; i < 10; i++) begin
         instr_retire = (i % 2 == 0);
         tick("ctr.run");
      end
      chk("ctr.run.cyc", cyc_ctr, 32'd10);
      chk("ctr.run.instr", instr_ctr, 32'd5);
      drive(3'd2, 32'h8000_0018, 32'h0, 1); instr_retire = 0;
      tick("ctr.clr1");
      chk("ctr.clr1.cyc", cyc_ctr, 32'd0);
      chk("ctr.clr1.instr", instr_ctr, 32'd0);
      store_en = 0;
      tick("ctr.post");
      chk("ctr.post.cyc", cyc_ctr, 32'd1);

      // Wrap at 2^32.
      force dut.u_ctr.cyc_q = 32'hFFFF_FFFF;
      force dut.u_ctr.instr_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_ctr.cyc_q;
      release dut.u_ctr.instr_q;
      m_cyc = 32'hFFFF_FFFF; m_instr = 32'hFFFF_FFFF;
      chk("wrap.preset", cyc_ctr, 32'hFFFF_FFFF);
      instr_retire = 1;
      tick("wrap");
      chk("wrap.cyc", cyc_ctr, 32'd0);
      chk("wrap.instr", instr_ctr, 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         logic [1:0] reg_sel;
         logic [31:0] a;
         reg_sel = 2'($urandom_range(0, 3));
         a = {reg_sel, 30'($urandom)};
         if (reg_sel == 2'b10) begin
            case ($urandom_range(0, 5))
               0, 1, 2: a[7:0] = 8'h08;
               3:       a[7:0] = 8'h18;
               default: ;
            endcase
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         end
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
         addr = a;
         data = $urandom;
         store_en = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 3) == 0);
         instr_retire = 1'($urandom);
         imem_wr_allow = 1'($urandom);
         ready = ($urandom_range(0, 2) == 0);
         #1;
         chk_comb_model($sformatf("rnd%0d", n));
         tick($sformatf("rnd%0d", n));
      end

      // Async reset while a byte is pending.
      stall = 0; ready = 0; instr_retire = 0;
      drive(3'd2, 32'h8000_0008, 32'h0000_0041, 1);
      tick("arst.load");
      store_en = 0;
      chk("arst.pre.valid", {31'd0, tx_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.valid", {31'd0, tx_valid}, 32'd0);
      chk("arst.status", {31'd0, status_ready}, 32'd1);
      chk("arst.byte", {24'd0, tx_byte}, 32'd0);
      chk("arst.cyc", cyc_ctr, 32'd0);
      m_cyc = '0; m_instr = '0; m_valid = 1'b0; m_byte = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick("arst.after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_store_unit.md
# mmio_store_unit

Store-side companion to the load-result mux. It turns a retiring store (address, data, funct3) into byte-lane write enables and lane-aligned write data for DMEM/IMEM, and handles memory-mapped IO writes: it holds one UART transmit byte with a valid/ready handshake and owns the cycle and instruction counters. Those counters, and the UART TX status, are read back through the load path. It sits in the MEM stage beside the load-result mux.

## Interface
- WIDTH, 32, datapath/address width; only 32 is supported.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- store_en  in  1  store instruction valid in MEM this cycle; ignored when stall=1.
- stall  in  1  pipeline stall; suppresses all store side effects.
- instr_retire  in  1  non-bubble instruction retires this cycle; ignored when stall=1.
- store_addr  in  32  effective address from the ALU.
- store_data  in  32  rs2 value, unshifted.
- store_funct3  in  3  store width: 000=SB, 001=SH, 010=SW; any other value performs no write.
- imem_wr_allow  in  1  IMEM writes are permitted (PC executing from BIOS).
- dmem_we  out  4  DMEM byte write enables, combinational.
- imem_we  out  4  IMEM byte write enables, combinational.
- mem_wdata  out  32  lane-replicated write data, combinational.
- misaligned  out  1  combinational flag: the current store is misaligned and was suppressed.
- uart_tx_data_in  out  8  byte to the UART transmitter.
- uart_tx_data_in_valid  out  1  TX byte valid, registered.
- uart_tx_data_in_ready  in  1  UART transmitter accepts the byte.
- uart_tx_status_ready  out  1  equals ~uart_tx_data_in_valid; feeds the load path's UART control bit 0.
- cyc_ctr  out  32  cycle counter, registered.
- instr_ctr  out  32  retired-instruction counter, registered.

## Operation
- The store is active when store_en & ~stall & funct3 is legal & the access is aligned.
- Alignment: SH requires addr[0]=0. SW requires addr[1:0]=00.
- A misaligned store drives misaligned=1 and has no side effects at all.
- Lane mask (SB): 0001 << addr[1:0]; wdata = {4{data[7:0]}}.
- Lane mask (SH): addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
- Lane mask (SW): 1111; wdata = data.
- mem_wdata is always driven per funct3, even for inactive stores.
- Region decode (addr[31:30]=00):
  - addr[28]=1 → dmem_we = lane mask.
  - addr[29]=1 & imem_wr_allow → imem_we = lane mask.
  - Both bits set → both memories are written.
- Region decode (addr[31:30]=01, BIOS): read-only; the store is ignored.
- IO region (addr[31:30]=10), decoded on addr[7:0]; other offsets are ignored:
  - 0x08 UART TX data: the byte written is data[7:0] regardless of width.
  - 0x18 counter reset.
- UART TX holding register:
  - If valid=0 at the edge of an active 0x08 store: latch the byte and set valid=1.
  - If valid=1 at that edge: the store is dropped. Software polls status first.
  - valid clears on the edge where valid & ready are both 1.
  - Byte and valid are held stable while valid=1 & ready=0.
- Counters:
  - cyc_ctr increments every cycle. instr_ctr increments when instr_retire & ~stall.
  - Both wrap at 2^32 (0xFFFFFFFF → 0).
  - An active 0x18 store clears both on that edge. Clear has priority over increment.

## Timing
- Reset values: uart_tx_data_in=0, valid=0, status_ready=1, cyc_ctr=0, instr_ctr=0.
- Combinational outputs depend only on their inputs during reset.
- Write enables and wdata are combinational, same cycle; the memories sample them at the edge.
- A TX store at edge N gives valid=1 after N. If ready=1 at edge N+1, valid=0 after N+1.
- Simultaneous TX store and handshake completion: the store sees valid=1, so it is dropped.
- Counter reset at edge N: cyc_ctr=0 after N and 1 after N+1.
- Reset asserted mid-handshake: valid drops immediately (asynchronous); the byte is lost.

## Structure
- Shared package holds the following constants:
  - region codes (DMEM bit 28, IMEM bit 29, IO 2'b10);
  - IO offsets: 0x00 UART control, 0x04 UART RX, 0x08 UART TX, 0x10 cycle, 0x14 instr, 0x18 counter reset;
  - funct3 codes SB/SH/SW.
- The load-path mux uses the same IO-offset constants.
- One sub-module, io_counters, contains the two 32-bit counters and the clear/increment priority.

## Test plan
- SB, addr=0x10000003, data=0x000000A5 → dmem_we=1000, mem_wdata=0xA5A5A5A5, imem_we=0000.
- SW, addr=0x30000004, data=0x12345678, imem_wr_allow=0 → dmem_we=1111, imem_we=0000. Repeat with imem_wr_allow=1 → imem_we=1111.
- SH, addr=0x10000001 → misaligned=1 and all write enables 0. The same store with stall=1 → no effect.
- SW 0x80000008, data=0x41, ready held 0 for 3 cycles:
  - valid=1 and byte 0x41 held stable;
  - a second TX store with 0x42 is dropped;
  - ready=1 → valid=0 and status_ready=1.
- Run 10 cycles with instr_retire toggling → cyc_ctr=10 and instr_ctr=5. Then SW to 0x80000018 → both counters 0, cyc_ctr=1 one cycle later.
- Force cyc_ctr to 0xFFFFFFFF → wraps to 0. Assert rst_n=0 asynchronously while valid=1 → valid=0 immediately.
